exu_wbck_arb: RTL

EXU_WBCK_ARB -- requirements
Module: exu_wbck_arb

---
 rtl/exu_wbck_arb_pkg.sv | 21 ++
 rtl/exu_wbck_arb_if.sv | 14 +
 rtl/exu_wbck_fifo.sv | 65 ++++++
 rtl/exu_wbck_arb.sv | 119 +++++++++++
 4 files changed

// File: rtl/exu_wbck_arb_pkg.sv
// Shared definitions for the EXU writeback arbiter: datapath widths,
// the grant-select encoding and the buffered LSU writeback payload.
package exu_wbck_arb_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned RFIDX_WIDTH = 5;

    // Which source owns the regfile write port this cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LSU  = 2'd2
    } gnt_sel_e;

    // One writeback entry as held in the LSU buffer.
    typedef struct packed {
        logic [RFIDX_WIDTH-1:0] rdidx;
        logic [XLEN-1:0]        wdat;
    } wbck_pld_t;

endpackage

// File: rtl/exu_wbck_arb_if.sv
// Writeback request channel (valid/ready handshake plus destination and data).
//   master : result producer (drives valid, wdat, rdidx; sees ready)
//   slave  : writeback arbiter (drives ready)
interface exu_wbck_arb_if
    import exu_wbck_arb_pkg::*;
();
    logic                   valid;
    logic                   ready;
    logic [XLEN-1:0]        wdat;
    logic [RFIDX_WIDTH-1:0] rdidx;

    modport master (output valid, output wdat, output rdidx, input ready);
    modport slave  (input valid, input wdat, input rdidx, output ready);
endinterface

// File: rtl/exu_wbck_fifo.sv
// Small synchronous FIFO for buffered LSU writebacks.
//   clk, rst_n          : clock, async active-low reset (pointers/count only)
//   push, wdata         : write side; caller must not push while full
//   pop, rdata          : read side; rdata is the current head
//   full, empty, count  : occupancy status, count spans 0..DEPTH
module exu_wbck_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer/occupancy update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/exu_wbck_arb.sv
// EXU writeback arbiter: merges the zero-latency ALU result path and the
// buffered LSU result path onto the single regfile write port.
//   clk, rst_n     : clock, async active-low reset
//   alu_wbck_i     : ALU result channel (ready is combinational grant)
//   lsu_wbck_i     : LSU load result channel (ready = buffer not full)
//   rf_wbck_o_*    : regfile write port; ena suppressed for x0
//   wbck_busy      : LSU buffer holds at least one entry
// Build option: WBCK_STARVE_GUARD_EN enables the ALU starvation guard
// (ALU forced a grant after STARVE_LIMIT stalled cycles); without it the
// LSU buffer has strict priority.
module exu_wbck_arb
    import exu_wbck_arb_pkg::*;
#(
    parameter int unsigned LSU_FIFO_DEPTH = 2,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    exu_wbck_arb_if.slave          alu_wbck_i,
    exu_wbck_arb_if.slave          lsu_wbck_i,
    output logic                   rf_wbck_o_ena,
    output logic [XLEN-1:0]        rf_wbck_o_wdat,
    output logic [RFIDX_WIDTH-1:0] rf_wbck_o_rdidx,
    output logic                   wbck_busy
);

    localparam int unsigned CNT_W = $clog2(LSU_FIFO_DEPTH+1);

    gnt_sel_e         gnt_sel;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;
    wbck_pld_t        lsu_pld;
    wbck_pld_t        fifo_head;
    logic             starve_win;

    assign lsu_pld.rdidx     = lsu_wbck_i.rdidx;
    assign lsu_pld.wdat      = lsu_wbck_i.wdat;
    assign lsu_wbck_i.ready  = !fifo_full;
    assign fifo_push         = lsu_wbck_i.valid && !fifo_full;
    assign fifo_pop          = (gnt_sel == GNT_LSU);

    exu_wbck_fifo #(
        .DEPTH (LSU_FIFO_DEPTH),
        .WIDTH ($bits(wbck_pld_t))
    ) u_lsu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (lsu_pld),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef WBCK_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT+1);

    logic [STV_W-1:0] stv_cnt_q, stv_cnt_d;

    // Saturating count of consecutive cycles the ALU waited behind the buffer.
    always_comb begin
        stv_cnt_d = stv_cnt_q;
        if (!alu_wbck_i.valid || (gnt_sel == GNT_ALU)) begin
            stv_cnt_d = '0;
        end else if (stv_cnt_q != STV_W'(STARVE_LIMIT)) begin
            stv_cnt_d = stv_cnt_q + STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stv_cnt_q <= '0;
        else        stv_cnt_q <= stv_cnt_d;
    end

    // Counter may still read saturated the cycle valid drops; only override when ALU is present.
    assign starve_win = alu_wbck_i.valid && (stv_cnt_q == STV_W'(STARVE_LIMIT));
`else
    localparam int unsigned UNUSED_STARVE_LIMIT = STARVE_LIMIT;
    assign starve_win = 1'b0;
`endif

    // Grant select: buffered LSU head first unless the ALU has starved.
    always_comb begin
        gnt_sel = GNT_NONE;
        if (!fifo_empty && !starve_win) begin
            gnt_sel = GNT_LSU;
        end else if (alu_wbck_i.valid) begin
            gnt_sel = GNT_ALU;
        end
    end

    assign alu_wbck_i.ready = (gnt_sel == GNT_ALU);

    // Regfile port mux; x0 writes complete the handshake but never enable.
    always_comb begin
        rf_wbck_o_wdat  = '0;
        rf_wbck_o_rdidx = '0;
        case (gnt_sel)
            GNT_ALU: begin
                rf_wbck_o_wdat  = alu_wbck_i.wdat;
                rf_wbck_o_rdidx = alu_wbck_i.rdidx;
            end
            GNT_LSU: begin
                rf_wbck_o_wdat  = fifo_head.wdat;
                rf_wbck_o_rdidx = fifo_head.rdidx;
            end
            default: ;
        endcase
        rf_wbck_o_ena = rst_n && (gnt_sel != GNT_NONE) && (rf_wbck_o_rdidx != '0);
    end

    assign wbck_busy = (fifo_count != '0);

endmodule
